link_rx: RTL

// - UART receiver and frame decoder for the inter-board snake link; the receiving end of the peer's frame transmitter.
// - Deserialises 8N1 bytes from the rx pin and decodes DIR, SEED and START frames.
// - Drives the remote direction, the seed handoff and the start_game strobe, plus link-health flags.
// - Sits between the rx pad and the move / generate_point / mode_control consumers, in the clk (75 MHz) domain.

---
 rtl/link_rx.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/link_rx.sv
// link_rx: UART (8N1) receiver and frame decoder for the inter-board snake link.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx         async serial input, idle high
//   dir_out    last received remote direction
//   rcvdir     1-cycle pulse, dir_out updated
//   seed_x_out received seed x
//   seed_y_out received seed y
//   seed_vld   1-cycle pulse, seed_x_out/seed_y_out updated together
//   start_game 1-cycle pulse, START frame received
//   frame_err  1-cycle pulse, bad stop bit, illegal byte or aborted SEED frame
//   link_lost  level, no good frame for TIMEOUT_CYC cycles
module link_rx #(
  parameter int CLK_HZ      = 75_000_000,
  parameter int BAUD        = 115_200,
  parameter int GAP_CYC     = 100_000,
  parameter int TIMEOUT_CYC = 75_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [1:0] dir_out,
  output logic       rcvdir,
  output logic [5:0] seed_x_out,
  output logic [5:0] seed_y_out,
  output logic       seed_vld,
  output logic       start_game,
  output logic       frame_err,
  output logic       link_lost
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int GW   = $clog2(GAP_CYC + 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYC);
  localparam logic [31:0]   TO_MAX  = 32'(TIMEOUT_CYC);

  // ---------------- byte receiver ----------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

  rstate_t         rstate;
  logic            rx_s1, rx_s2, rx_d;
  logic [CW-1:0]   cnt;
  logic [2:0]      bidx;
  logic [7:0]      shreg;
  logic            tick;
  logic            byte_vld;
  logic            rx_ferr;

  // Start bit is checked at its middle; every later sample is one full bit on.
  assign tick     = (rstate == R_START) ? (cnt == HALF_M1) : (cnt == CPB_M1);
  // Stop-bit outcome is combinational so the decoder can react on the same edge.
  assign byte_vld = (rstate == R_STOP) && tick && rx_s2;
  assign rx_ferr  = (rstate == R_STOP) && tick && !rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_d   <= 1'b1;
      rstate <= R_IDLE;
      cnt    <= '0;
      bidx   <= '0;
      shreg  <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      case (rstate)
        R_IDLE: begin
          cnt <= '0;
          // Edge, not level: a line still low after a bad stop bit must not restart.
          if (rx_d && !rx_s2) rstate <= R_START;
        end
        R_START: begin
          if (tick) begin
            cnt    <= '0;
            bidx   <= '0;
            rstate <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (tick) begin
            cnt   <= '0;
            shreg <= {rx_s2, shreg[7:1]};
            bidx  <= bidx + 3'd1;
            if (bidx == 3'd7) rstate <= R_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (tick) begin
            cnt    <= '0;
            rstate <= R_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- frame decoder ----------------
  typedef enum logic [1:0] {F_IDLE, F_SX, F_SY} fstate_t;

  fstate_t        fstate;
  logic [5:0]     x_hold;
  logic [GW-1:0]  gap;
  logic           is_dir;
  logic           good;
  logic [31:0]    timer;

  always_comb begin
    is_dir = (shreg[7:6] == 2'b01) && (shreg[5:2] == 4'd0);
    good   = 1'b0;
    if (byte_vld) begin
      if (fstate == F_IDLE)
        good = (shreg == 8'h00) || is_dir || (shreg == 8'hC0);
      else if (fstate == F_SY)
        good = (shreg[7:6] == 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fstate     <= F_IDLE;
      x_hold     <= '0;
      gap        <= '0;
      dir_out    <= '0;
      seed_x_out <= '0;
      seed_y_out <= '0;
      rcvdir     <= 1'b0;
      seed_vld   <= 1'b0;
      start_game <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rcvdir     <= 1'b0;
      seed_vld   <= 1'b0;
      start_game <= 1'b0;
      frame_err  <= 1'b0;
      if (fstate == F_IDLE)    gap <= '0;
      else if (gap != GAP_MAX) gap <= gap + 1'b1;

      if (rx_ferr) begin
        // A broken byte always reports and kills any SEED frame in progress.
        frame_err <= 1'b1;
        fstate    <= F_IDLE;
      end else if (byte_vld) begin
        gap <= '0;
        case (fstate)
          F_IDLE: begin
            if (shreg == 8'h00) begin
              // keepalive: only refreshes the link timer
            end else if (is_dir) begin
              dir_out <= shreg[1:0];
              rcvdir  <= 1'b1;
            end else if (shreg == 8'h80) begin
              fstate <= F_SX;
            end else if (shreg == 8'hC0) begin
              start_game <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          F_SX: begin
            if (shreg[7:6] == 2'b00) begin
              x_hold <= shreg[5:0];
              fstate <= F_SY;
            end else begin
              frame_err <= 1'b1;
              fstate    <= F_IDLE;
            end
          end
          F_SY: begin
            if (shreg[7:6] == 2'b00) begin
              seed_x_out <= x_hold;
              seed_y_out <= shreg[5:0];
              seed_vld   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            fstate <= F_IDLE;
          end
          default: fstate <= F_IDLE;
        endcase
      end else if (fstate != F_IDLE && gap == GAP_MAX) begin
        frame_err <= 1'b1;
        fstate    <= F_IDLE;
      end
    end
  end

  // ---------------- link health ----------------
  always_ff @(posedge clk) begin
    if (rst)                timer <= '0;
    else if (good)          timer <= '0;
    else if (timer != '1)   timer <= timer + 32'd1;
  end

  assign link_lost = (timer >= TO_MAX);

endmodule
